line_backing_memory: RTL and testbench

Block-granular backing memory that sits directly downstream of the data cache and serves its line fills and dirty-line write-backs. Accepts one line request at a time through a valid/ready handshake, models a fixed access latency with a down-counter, and returns a full line for reads. It is the only path from the cache to main storage, so its timing sets the cache miss penalty.

---
 rtl/line_backing_memory.sv | 115 +++++++++++
 tb/tb_line_backing_memory.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/line_backing_memory.sv
// Line-granular backing store behind the data cache: one line request at a time, fixed access latency.
// Latency DELAY cycles from accept to response; mem_ready is low from accept until the response cycle ends.
module line_backing_memory #(
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_LINES  = 256,
    parameter int DELAY      = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    is_input_valid,
    input  logic [31:0]             addr,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [BLOCK_SIZE*8-1:0] din,
    output logic                    is_output_valid,
    output logic [BLOCK_SIZE*8-1:0] dout,
    output logic                    mem_ready
);
    localparam int OFF_W  = $clog2(BLOCK_SIZE);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int CNT_W  = $clog2(DELAY + 1);
    localparam int LINE_W = BLOCK_SIZE * 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESPOND
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic                r_is_read;
    logic [LINE_W-1:0]   r_wdat;
    logic [LINE_W-1:0]   r_mem [NUM_LINES];
    logic                r_ready;
    logic                r_out_vld;
    logic [LINE_W-1:0]   r_dout;

    logic                w_accept;
    logic [IDX_W-1:0]    w_idx;
    logic                w_unused_addr;

    // Upper address bits alias onto the same lines by design.
    assign w_idx         = addr[OFF_W+IDX_W-1:OFF_W];
    assign w_unused_addr = ^{addr[31:OFF_W+IDX_W], addr[OFF_W-1:0]};
    assign w_accept      = is_input_valid && r_ready && (mem_read ^ mem_write);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_is_read <= 1'b0;
            r_wdat    <= '0;
            r_ready   <= 1'b1;
            r_out_vld <= 1'b0;
            r_dout    <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_out_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_idx     <= w_idx;
                        r_is_read <= mem_read;
                        r_wdat    <= din;
                        r_cnt     <= CNT_W'(DELAY - 1);
                        r_ready   <= 1'b0;
                        if (DELAY > 1) begin
                            r_state <= S_BUSY;
                        end else begin
                            // Single-cycle latency: respond straight from the incoming index.
                            r_state   <= S_RESPOND;
                            r_out_vld <= mem_read;
                            if (mem_read) begin
                                r_dout <= r_mem[w_idx];
                            end
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                    if ((r_cnt == CNT_W'(1)) || (r_cnt == '0)) begin
                        r_state   <= S_RESPOND;
                        r_out_vld <= r_is_read;
                        if (r_is_read) begin
                            r_dout <= r_mem[r_idx];
                        end
                    end
                end
                S_RESPOND: begin
                    if (!r_is_read) begin
                        r_mem[r_idx] <= r_wdat;
                    end
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign is_output_valid = r_out_vld;
    assign dout            = r_dout;
    assign mem_ready       = r_ready;

endmodule

// File: tb/tb_line_backing_memory.sv
// Drives a DELAY=4 and a DELAY=1 instance with identical stimulus; each has its own reference model and scoreboard.
module tb_line_backing_memory;
    typedef struct {
        logic [127:0] dat;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         is_input_valid;
    logic [31:0]  addr;
    logic         mem_read;
    logic         mem_write;
    logic [127:0] din;
    logic         end_chk;
    int           cyc;
    int           n_checks;
    int           n_errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int D = (g == 0) ? 4 : 1;
        logic         vld;
        logic [127:0] dout;
        logic         rdy;
        logic [127:0] model [256];
        exp_t         q[$];
        int           next_free;
        logic [127:0] last_dout;
        string        pfx;

        line_backing_memory #(
            .BLOCK_SIZE(16),
            .NUM_LINES (256),
            .DELAY     (D)
        ) u_dut (
            .clk            (clk),
            .reset          (reset),
            .is_input_valid (is_input_valid),
            .addr           (addr),
            .mem_read       (mem_read),
            .mem_write      (mem_write),
            .din            (din),
            .is_output_valid(vld),
            .dout           (dout),
            .mem_ready      (rdy)
        );

        initial begin
            pfx       = (g == 0) ? "d4" : "d1";
            next_free = 0;
            last_dout = '0;
        end

        always @(negedge clk) begin
            exp_t       e;
            logic       exp_vld;
            logic [7:0] idx;
            if (reset) begin
                for (int i = 0; i < 256; i++) model[i] = '0;
                q.delete();
                next_free = 0;
                last_dout = '0;
            end else begin
                check_eq({pfx, "_rdy"}, rdy, cyc >= next_free);
                exp_vld = (q.size() > 0) && (q[0].cyc == cyc);
                check_eq({pfx, "_vld"}, vld, exp_vld);
                if (exp_vld) begin
                    e = q.pop_front();
                    last_dout = e.dat;
                end
                check_eq({pfx, "_dout"}, dout, last_dout);
                if (is_input_valid && (cyc >= next_free) && (mem_read ^ mem_write)) begin
                    idx = addr[11:4];
                    if (mem_read) q.push_back('{dat: model[idx], cyc: cyc + D});
                    else model[idx] = din;
                    next_free = cyc + D + 1;
                end
                if (end_chk) check_eq({pfx, "_q_empty"}, q.size(), 0);
            end
        end
    end

    task automatic drive(input logic v, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [127:0] d, input int n);
        is_input_valid = v;
        mem_read       = rd;
        mem_write      = wr;
        addr           = a;
        din            = d;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 1'b0, 32'h0, '0, n);
    endtask

    initial begin
        logic [127:0] pat;
        int           op;
        logic [31:0]  a;
        n_checks       = 0;
        n_errors       = 0;
        end_chk        = 1'b0;
        reset          = 1'b1;
        is_input_valid = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        addr           = '0;
        din            = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Read of a freshly reset line, then write and aliased read-backs.
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0040, '0, 1);
        idle(4);
        pat = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0040, pat, 1);
        idle(4);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_004C, '0, 1);
        idle(4);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_1040, '0, 1);
        idle(4);

        // Request held high: only accepted when the block is ready.
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0040, '0, 12);
        idle(5);

        // Both or neither op bit set: ignored.
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0040, '1, 3);
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0040, '1, 1);
        idle(2);

        // Reset in the middle of a write abandons it.
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0080, '1, 1);
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0080, '0, 1);
        idle(4);

        // Write data changing after accept must not leak into the array.
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0200, 128'h1111, 1);
        drive(1'b0, 1'b0, 1'b0, 32'h0000_0200, 128'h2222, 4);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0200, '0, 1);
        idle(4);

        for (int i = 0; i < 40; i++) begin
            op  = $urandom_range(0, 3);
            a   = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
            pat = {$urandom, $urandom, $urandom, $urandom};
            case (op)
                0:       drive(1'b1, 1'b1, 1'b0, a, pat, 1);
                1:       drive(1'b1, 1'b0, 1'b1, a, pat, 1);
                2:       drive(1'b1, 1'b1, 1'b1, a, pat, 1);
                default: drive(1'b1, 1'b1, 1'b0, a, pat, 2);
            endcase
            idle($urandom_range(3, 6));
        end

        idle(8);
        end_chk = 1'b1;
        idle(1);
        end_chk = 1'b0;
        idle(1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
